// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared FSM state encoding and default sizing for the lane FIFO controller
package fifo_ctrl_pkg;
    localparam int DEF_ARRAY_SIZE = 9;
    localparam int DEF_FIFO_DEPTH = 256;
    localparam int DEF_LOG_DEPTH  = 8;
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FEED, DONE} state_t;
endpackage

// File: rtl/fifo_array_ctrl_feed_skew.sv
// feed_skew: per-lane read window, lane i reads while i <= t < i+rows
// ports: en (FEED active), t (feed cycle), rows (words per lane), r_en (lane read enables)
module feed_skew
    import fifo_ctrl_pkg::*;
#(
    parameter int array_size = DEF_ARRAY_SIZE,
    parameter int tw         = 9
) (
    input  logic                  en,
    input  logic [tw-1:0]         t,
    input  logic [tw-1:0]         rows,
    output logic [array_size-1:0] r_en
);
    for (genvar i = 0; i < array_size; i++) begin : g_lane
        assign r_en[i] = en && t >= tw'(i) && t < tw'(i) + rows;
    end
endmodule

// File: rtl/fifo_array_ctrl.sv
// fifo_array_ctrl: loads words round-robin into per-row lane FIFOs, then drains them with a diagonal skew
// ports: clk/rst_n, start+cfg_rows (job request), in_valid/in_ready (source handshake),
//        fifo_w_en/fifo_r_en/fifo_clear/fifo_full/fifo_empty (lane FIFO array), feed_valid (read data valid),
//        busy/done/err_cfg/err_underflow (status)
module fifo_array_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int array_size = DEF_ARRAY_SIZE,
    parameter int fifo_depth = DEF_FIFO_DEPTH,
    parameter int log_depth  = DEF_LOG_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [log_depth:0]    cfg_rows,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [array_size-1:0] fifo_w_en,
    output logic [array_size-1:0] fifo_r_en,
    output logic                  fifo_clear,
    input  logic [array_size-1:0] fifo_full,
    input  logic [array_size-1:0] fifo_empty,
    output logic [array_size-1:0] feed_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg,
    output logic                  err_underflow
);
    localparam int rw = log_depth + 1;
    // t must reach rows+array_size-2 with rows=fifo_depth without wrapping
    localparam int tw = $clog2(fifo_depth + array_size);
    localparam int cw = array_size > 1 ? $clog2(array_size) : 1;
    state_t          state;
    logic [cw-1:0]   col;
    logic [rw-1:0]   row;
    logic [rw-1:0]   rows;
    logic [tw-1:0]   t;
    logic [tw-1:0]   t_last;
    logic            xfer;
    logic            cfg_ok;
    assign in_ready   = (state == LOAD) && !fifo_full[col];
    assign xfer       = in_valid && in_ready;
    assign fifo_w_en  = xfer ? array_size'(1) << col : '0;
    assign fifo_clear = state == CLEAR;
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign cfg_ok     = cfg_rows != '0 && cfg_rows <= rw'(fifo_depth);
    assign t_last     = tw'(rows) + tw'(array_size - 2);
    feed_skew #(.array_size(array_size), .tw(tw)) u_skew (
        .en   (state == FEED),
        .t    (t),
        .rows (tw'(rows)),
        .r_en (fifo_r_en)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            rows          <= '0;
            t             <= '0;
            feed_valid    <= '0;
            err_cfg       <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_cfg    <= 1'b0;
            feed_valid <= fifo_r_en;
            if (|(fifo_r_en & fifo_empty)) err_underflow <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    if (cfg_ok) begin
                        rows          <= cfg_rows;
                        err_underflow <= 1'b0;
                        state         <= CLEAR;
                    end else begin
                        err_cfg <= 1'b1;
                    end
                end
                CLEAR: begin
                    col   <= '0;
                    row   <= '0;
                    state <= LOAD;
                end
                LOAD: if (xfer) begin
                    if (col == cw'(array_size - 1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                        if (row == rows - 1'b1) begin
                            t     <= '0;
                            state <= FEED;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                FEED: begin
                    t <= t + 1'b1;
                    if (t == t_last) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fifo_array_ctrl.md
FIFO_ARRAY_CTRL -- requirements
Module: fifo_array_ctrl

Interface
REQ-001 SHALL have parameter array_size, default 9, number of FIFO lanes (one per systolic row).
REQ-002 SHALL have parameter fifo_depth, default 256, words per lane FIFO.
REQ-003 SHALL have parameter log_depth, default 8, equal to log2(fifo_depth).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, begins a load-then-feed job.
REQ-007 SHALL have port cfg_rows, input, log_depth+1, words per lane for the job.
REQ-008 SHALL have port in_valid, input, 1, the source word is valid.
REQ-009 SHALL have port in_ready, output, 1, the controller accepts the word.
REQ-010 SHALL have port fifo_w_en, output, array_size, per-lane write enable.
REQ-011 SHALL have port fifo_r_en, output, array_size, per-lane read enable.
REQ-012 SHALL have port fifo_clear, output, 1, clears all lane FIFOs.
REQ-013 SHALL have ports fifo_full and fifo_empty, input, array_size each, lane status.
REQ-014 SHALL have port feed_valid, output, array_size, fifo_r_en delayed by one cycle (FIFO read data valid).
REQ-015 SHALL have ports busy, done, err_cfg and err_underflow, output, 1 each.

Function
REQ-016 SHALL implement states IDLE, CLEAR, LOAD, FEED and DONE; busy=1 in every state except IDLE.
REQ-017 SHALL, in IDLE with start=1 and 1<=cfg_rows<=fifo_depth, latch rows=cfg_rows, clear err_underflow and go to CLEAR.
REQ-018 SHALL, in IDLE with start=1 and cfg_rows outside that range, pulse err_cfg for one cycle and stay in IDLE.
REQ-019 SHALL ignore start in every state except IDLE.
REQ-020 SHALL assert fifo_clear for exactly one cycle in CLEAR, then go to LOAD with col=0 and row=0.
REQ-021 SHALL drive in_ready = (state==LOAD) && !fifo_full[col], combinationally.
REQ-022 SHALL treat a cycle with in_valid && in_ready as a transfer; fifo_w_en[col]=1 in that same cycle only, one-hot.
REQ-023 SHALL, on each transfer, wrap col from array_size-1 to 0 and increment row; otherwise col increments.
REQ-024 SHALL go to FEED with t=0 after the transfer with row==rows-1 and col==array_size-1.
REQ-025 SHALL, in FEED, set fifo_r_en[i]=1 exactly when i <= t < i+rows (diagonal skew) and increment t every cycle.
REQ-026 SHALL go to DONE after t==rows+array_size-2; DONE lasts one cycle with done=1, then returns to IDLE.
REQ-027 SHALL set err_underflow (sticky until the next accepted start) when fifo_r_en[i] && fifo_empty[i] in any cycle.
REQ-028 SHALL size t and row so that no wrap occurs at rows=fifo_depth.

Reset
REQ-029 SHALL, on rst_n=0 in any state, force IDLE and zero col, row, t, rows, and every output, including feed_valid, fifo_clear and the error flags.
REQ-030 SHALL resume normally from IDLE after rst_n is deasserted; a job in progress is discarded.

Structure
REQ-031 SHALL place the state encoding and default parameter constants in shared package fifo_ctrl_pkg.
REQ-032 SHALL implement the per-lane window compare of REQ-025 in one sub-module, feed_skew, instantiated once and generating all array_size lanes.
REQ-033 SHALL connect its outputs directly to the fifo_array enable, clear and status ports with no glue logic.

Verification
REQ-034 SHALL test: rows=1, array_size=9, 9 back-to-back words -> w_en one-hot lanes 0..8; FEED lasts 9 cycles with r_en[i] only at t=i; done asserts 1 cycle after t=8.
REQ-035 SHALL test: rows=4 with in_valid toggling every other cycle -> exactly 36 w_en pulses; r_en[3] is high for t=3..6; FEED lasts 12 cycles.
REQ-036 SHALL test: fifo_full[3] forced high during LOAD -> in_ready=0 while col==3; no w_en is issued; the job resumes when full is released.
REQ-037 SHALL test: start with cfg_rows=0, then with cfg_rows=257 -> err_cfg pulses once each, busy stays 0, no fifo_clear.
REQ-038 SHALL test: rst_n pulsed low at FEED t=5 -> all outputs 0 asynchronously, IDLE; a new job then completes correctly.
REQ-039 SHALL test: fifo_empty[2] forced high during FEED -> err_underflow=1 and held until the next start.
